// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with arbitrary depth, standard or first-word-fall-through
// read mode, run-time almost-full/almost-empty thresholds, fill count, synchronous flush
// and sticky overflow/underflow flags.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   din             write data
//   write / read    write and read requests
//   flush           synchronous clear of contents (overrides read/write)
//   clr_err         clears the sticky error flags (a same-cycle new error wins)
//   almost_full_th  almost_full  = count >= almost_full_th
//   almost_empty_th almost_empty = count <= almost_empty_th
//   dout            read data (registered in standard mode, combinational in FWFT mode)
//   empty / full    count == 0 / count == DEPTH
//   count           words stored, 0..DEPTH
//   overflow        sticky: a write was rejected
//   underflow       sticky: a read was attempted while empty
module sync_fifo #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned FWFT   = 0,
  parameter int unsigned CWIDTH = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] din,
  input  logic              write,
  input  logic              read,
  input  logic              flush,
  input  logic              clr_err,
  input  logic [CWIDTH-1:0] almost_full_th,
  input  logic [CWIDTH-1:0] almost_empty_th,
  output logic [DWIDTH-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CWIDTH-1:0] count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned PWIDTH = $clog2(DEPTH);

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [PWIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [PWIDTH-1:0] w_wr_ptr_d, w_rd_ptr_d;
  logic [CWIDTH-1:0] r_count, w_count_d;
  logic              r_overflow, r_underflow;
  logic              w_empty, w_full;
  logic              w_ren, w_wen;
  logic              w_ovf_set, w_unf_set;

  // Wrap by explicit compare so non-power-of-2 depths work.
  function automatic logic [PWIDTH-1:0] ptr_inc(input logic [PWIDTH-1:0] p);
    return (p == PWIDTH'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CWIDTH'(DEPTH));

  // flush suppresses both requests; when full a write rides on a same-cycle read.
  assign w_ren = read & ~w_empty & ~flush;
  assign w_wen = write & (~w_full | w_ren) & ~flush;

  assign w_ovf_set = write & ~w_wen & ~flush;
  assign w_unf_set = read & w_empty & ~flush;

  always_comb begin
    w_wr_ptr_d = r_wr_ptr;
    w_rd_ptr_d = r_rd_ptr;
    w_count_d  = r_count;
    if (flush) begin
      w_wr_ptr_d = '0;
      w_rd_ptr_d = '0;
      w_count_d  = '0;
    end else begin
      if (w_wen) w_wr_ptr_d = ptr_inc(r_wr_ptr);
      if (w_ren) w_rd_ptr_d = ptr_inc(r_rd_ptr);
      if (w_wen && !w_ren) begin
        w_count_d = r_count + 1'b1;
      end else if (w_ren && !w_wen) begin
        w_count_d = r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_d;
      r_rd_ptr    <= w_rd_ptr_d;
      r_count     <= w_count_d;
      r_overflow  <= (r_overflow & ~clr_err) | w_ovf_set;
      r_underflow <= (r_underflow & ~clr_err) | w_unf_set;
    end
  end

  // Storage is not reset. A full-with-read collision reads the old word because the
  // read samples the array before this edge's write lands.
  always_ff @(posedge clk) begin
    if (w_wen) r_mem[r_wr_ptr] <= din;
  end

  if (FWFT != 0) begin : g_fwft
    assign dout = r_mem[r_rd_ptr];
  end else begin : g_std
    logic [DWIDTH-1:0] r_dout;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_dout <= '0;
      end else if (w_ren) begin
        r_dout <= r_mem[r_rd_ptr];
      end
    end
    assign dout = r_dout;
  end

  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_full  = (r_count >= almost_full_th);
  assign almost_empty = (r_count <= almost_empty_th);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: a standard-mode and an FWFT-mode instance
// (DEPTH=5, DWIDTH=8) share the same stimulus.
module tb_sync_fifo;

  localparam int unsigned DW = 8;
  localparam int unsigned DP = 5;
  localparam int unsigned CW = 3;

  logic          clk, rst_n;
  logic [DW-1:0] din;
  logic          wr, rd, fl, ce;
  logic [CW-1:0] af_th, ae_th;

  logic [DW-1:0] s_dout, f_dout;
  logic          s_empty, s_full, s_af, s_ae, s_ovf, s_unf;
  logic          f_empty, f_full, f_af, f_ae, f_ovf, f_unf;
  logic [CW-1:0] s_count, f_count;

  int total = 0;
  int bad   = 0;

  sync_fifo #(.DWIDTH(DW), .DEPTH(DP), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .din(din), .write(wr), .read(rd), .flush(fl),
    .clr_err(ce), .almost_full_th(af_th), .almost_empty_th(ae_th),
    .dout(s_dout), .empty(s_empty), .full(s_full), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo #(.DWIDTH(DW), .DEPTH(DP), .FWFT(1)) u_fw (
    .clk(clk), .rst_n(rst_n), .din(din), .write(wr), .read(rd), .flush(fl),
    .clr_err(ce), .almost_full_th(af_th), .almost_empty_th(ae_th),
    .dout(f_dout), .empty(f_empty), .full(f_full), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          wr, rd, fl, ce;
    logic [DW-1:0] din;
    logic [CW-1:0] cnt;
    logic          ovf, unf;
    logic [DW-1:0] dout;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic w, input logic r, input logic c,
                             input logic [DW-1:0] d, input logic [CW-1:0] n,
                             input logic o, input logic u, input logic [DW-1:0] q);
    vec_t x;
    x.wr = w; x.rd = r; x.fl = 1'b0; x.ce = c; x.din = d;
    x.cnt = n; x.ovf = o; x.unf = u; x.dout = q;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic f, input logic c,
                       input logic [DW-1:0] d);
    wr = w; rd = r; fl = f; ce = c; din = d;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, '0);
    af_th = '0;
    ae_th = 3'd1;

    // Reset state, checked while reset is held.
    #2;
    chk("rst count", s_count, 0);
    chk("rst empty", s_empty, 1);
    chk("rst full", s_full, 0);
    chk("rst dout", s_dout, 0);
    chk("rst ae", s_ae, 1);
    chk("rst af th0", s_af, 1);
    chk("rst ovf", s_ovf, 0);
    chk("rst unf", s_unf, 0);
    af_th = 3'd3;
    #1;
    chk("rst af th3", s_af, 0);
    tick();
    rst_n = 1'b1;

    // Phase A: fill, overflow, full read+write collision, drain, underflow, clr_err.
    tbl.push_back(v(1, 0, 0, 8'hA0, 1, 0, 0, 8'h00));
    tbl.push_back(v(1, 0, 0, 8'hA1, 2, 0, 0, 8'h00));
    tbl.push_back(v(1, 0, 0, 8'hA2, 3, 0, 0, 8'h00));
    tbl.push_back(v(1, 0, 0, 8'hA3, 4, 0, 0, 8'h00));
    tbl.push_back(v(1, 0, 0, 8'hA4, 5, 0, 0, 8'h00));
    tbl.push_back(v(1, 0, 0, 8'hA5, 5, 1, 0, 8'h00));
    tbl.push_back(v(0, 0, 1, 8'h00, 5, 0, 0, 8'h00));
    tbl.push_back(v(1, 1, 0, 8'hB0, 5, 0, 0, 8'hA0));
    tbl.push_back(v(0, 1, 0, 8'h00, 4, 0, 0, 8'hA1));
    tbl.push_back(v(0, 1, 0, 8'h00, 3, 0, 0, 8'hA2));
    tbl.push_back(v(0, 1, 0, 8'h00, 2, 0, 0, 8'hA3));
    tbl.push_back(v(0, 1, 0, 8'h00, 1, 0, 0, 8'hA4));
    tbl.push_back(v(0, 1, 0, 8'h00, 0, 0, 0, 8'hB0));
    tbl.push_back(v(0, 1, 0, 8'h00, 0, 0, 1, 8'hB0));
    tbl.push_back(v(0, 0, 1, 8'h00, 0, 0, 0, 8'hB0));
    tbl.push_back(v(1, 1, 0, 8'hC0, 1, 0, 1, 8'hB0));
    tbl.push_back(v(0, 1, 0, 8'h00, 0, 0, 1, 8'hC0));
    tbl.push_back(v(0, 1, 1, 8'h00, 0, 0, 1, 8'hC0));
    tbl.push_back(v(0, 0, 1, 8'h00, 0, 0, 0, 8'hC0));
    // Phase B: 12-word stream with stalls; read pointer wraps twice.
    tbl.push_back(v(1, 0, 0, 8'h00, 1, 0, 0, 8'hC0));
    tbl.push_back(v(1, 0, 0, 8'h01, 2, 0, 0, 8'hC0));
    tbl.push_back(v(1, 1, 0, 8'h02, 2, 0, 0, 8'h00));
    tbl.push_back(v(0, 0, 0, 8'h00, 2, 0, 0, 8'h00));
    tbl.push_back(v(1, 1, 0, 8'h03, 2, 0, 0, 8'h01));
    tbl.push_back(v(1, 1, 0, 8'h04, 2, 0, 0, 8'h02));
    tbl.push_back(v(0, 1, 0, 8'h00, 1, 0, 0, 8'h03));
    tbl.push_back(v(1, 0, 0, 8'h05, 2, 0, 0, 8'h03));
    tbl.push_back(v(1, 0, 0, 8'h06, 3, 0, 0, 8'h03));
    tbl.push_back(v(1, 1, 0, 8'h07, 3, 0, 0, 8'h04));
    tbl.push_back(v(1, 1, 0, 8'h08, 3, 0, 0, 8'h05));
    tbl.push_back(v(1, 0, 0, 8'h09, 4, 0, 0, 8'h05));
    tbl.push_back(v(0, 0, 0, 8'h00, 4, 0, 0, 8'h05));
    tbl.push_back(v(1, 1, 0, 8'h0A, 4, 0, 0, 8'h06));
    tbl.push_back(v(1, 1, 0, 8'h0B, 4, 0, 0, 8'h07));
    tbl.push_back(v(0, 1, 0, 8'h00, 3, 0, 0, 8'h08));
    tbl.push_back(v(0, 0, 0, 8'h00, 3, 0, 0, 8'h08));
    tbl.push_back(v(0, 1, 0, 8'h00, 2, 0, 0, 8'h09));
    tbl.push_back(v(0, 1, 0, 8'h00, 1, 0, 0, 8'h0A));
    tbl.push_back(v(0, 1, 0, 8'h00, 0, 0, 0, 8'h0B));

    foreach (tbl[i]) begin
      drive(tbl[i].wr, tbl[i].rd, tbl[i].fl, tbl[i].ce, tbl[i].din);
      tick();
      chk($sformatf("vec%0d count", i), s_count, tbl[i].cnt);
      chk($sformatf("vec%0d empty", i), s_empty, tbl[i].cnt == 0);
      chk($sformatf("vec%0d full", i), s_full, tbl[i].cnt == CW'(DP));
      chk($sformatf("vec%0d af", i), s_af, tbl[i].cnt >= 3);
      chk($sformatf("vec%0d ae", i), s_ae, tbl[i].cnt <= 1);
      chk($sformatf("vec%0d ovf", i), s_ovf, tbl[i].ovf);
      chk($sformatf("vec%0d unf", i), s_unf, tbl[i].unf);
      chk($sformatf("vec%0d dout", i), s_dout, tbl[i].dout);
      chk($sformatf("vec%0d fw count", i), f_count, tbl[i].cnt);
    end
    drive(0, 0, 0, 0, '0);

    // Thresholds 3/1 across fill levels 0..5.
    for (int i = 0; i <= 5; i++) begin
      chk($sformatf("th lvl%0d af", i), s_af, i >= 3);
      chk($sformatf("th lvl%0d ae", i), s_ae, i <= 1);
      if (i < 5) begin
        drive(1, 0, 0, 0, DW'(8'h50 + i));
        tick();
        drive(0, 0, 0, 0, '0);
      end
    end
    drive(0, 1, 0, 0, '0);
    tick();
    drive(0, 0, 0, 0, '0);
    chk("th cnt4 af", s_af, 1);
    chk("th cnt4 dout", s_dout, 8'h50);
    af_th = 3'd5;
    ae_th = 3'd4;
    #1;
    chk("th change af", s_af, 0);
    chk("th change ae", s_ae, 1);
    af_th = 3'd3;
    ae_th = 3'd1;
    drive(0, 1, 0, 0, '0);
    tick();
    chk("pre flush count", s_count, 3);
    chk("pre flush dout", s_dout, 8'h51);

    // Flush at count 3 with read and write also asserted.
    drive(1, 1, 1, 0, 8'hEE);
    tick();
    drive(0, 0, 0, 0, '0);
    chk("flush count", s_count, 0);
    chk("flush empty", s_empty, 1);
    chk("flush ovf", s_ovf, 0);
    chk("flush unf", s_unf, 0);
    chk("flush dout hold", s_dout, 8'h51);
    drive(1, 0, 0, 0, 8'h66);
    tick();
    drive(0, 1, 0, 0, '0);
    tick();
    drive(0, 0, 0, 0, '0);
    chk("post flush data", s_dout, 8'h66);

    // FWFT behaviour.
    drive(1, 0, 0, 0, 8'h11);
    tick();
    drive(0, 0, 0, 0, '0);
    chk("fw empty", f_empty, 0);
    chk("fw dout 11", f_dout, 8'h11);
    tick();
    chk("fw dout hold", f_dout, 8'h11);
    drive(0, 1, 0, 0, '0);
    tick();
    chk("fw pop empty", f_empty, 1);
    chk("std dout 11", s_dout, 8'h11);
    tick();
    drive(0, 0, 0, 0, '0);
    chk("fw underflow", f_unf, 1);
    drive(0, 0, 0, 1, '0);
    tick();
    chk("fw clr_err", f_unf, 0);
    drive(1, 0, 0, 0, 8'h22);
    tick();
    drive(1, 0, 0, 0, 8'h33);
    tick();
    drive(0, 0, 0, 0, '0);
    chk("fw head 22", f_dout, 8'h22);
    drive(0, 1, 0, 0, '0);
    tick();
    chk("fw head 33", f_dout, 8'h33);
    tick();
    drive(0, 0, 0, 0, '0);
    chk("fw drained", f_count, 0);

    // Asynchronous reset mid-burst with overflow set.
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 0, DW'(8'h80 + i));
      tick();
    end
    chk("burst full", s_full, 1);
    chk("burst ovf", s_ovf, 1);
    drive(1, 1, 0, 0, 8'h90);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async count", s_count, 0);
    chk("async empty", s_empty, 1);
    chk("async full", s_full, 0);
    chk("async dout", s_dout, 0);
    chk("async ovf", s_ovf, 0);
    chk("async unf", s_unf, 0);
    chk("async ae", s_ae, 1);
    chk("async af", s_af, 0);
    drive(0, 0, 0, 0, '0);
    tick();
    rst_n = 1'b1;
    chk("held count", s_count, 0);
    drive(1, 0, 0, 0, 8'h77);
    tick();
    drive(0, 1, 0, 0, '0);
    tick();
    drive(0, 0, 0, 0, '0);
    chk("post rst data", s_dout, 8'h77);
    chk("post rst count", s_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, parametrised FIFO; the general-purpose in-clock-domain buffer for datapath blocks.
- Adds features the basic FIFO lacks:
  - arbitrary (non-power-of-2) depth
  - selectable standard or first-word-fall-through (FWFT) read mode
  - run-time almost-full/almost-empty thresholds
  - fill-level count output
  - synchronous flush
  - sticky overflow/underflow error flags

Parameters:
- DWIDTH, 32, data width in bits.
- DEPTH, 16, number of storage words; any integer >= 2.
- FWFT, 0, read mode: 0 = standard (registered dout, 1-cycle read latency); 1 = first-word-fall-through.
- CWIDTH, $clog2(DEPTH+1), width of count and threshold ports (derived; do not override).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  DWIDTH  write data.
- write  input  1  write request.
- read  input  1  read request.
- flush  input  1  synchronous clear of FIFO contents.
- clr_err  input  1  clears sticky overflow/underflow.
- almost_full_th  input  CWIDTH  almost_full asserted when count >= this.
- almost_empty_th  input  CWIDTH  almost_empty asserted when count <= this.
- dout  output  DWIDTH  read data.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- almost_full  output  1  threshold flag.
- almost_empty  output  1  threshold flag.
- count  output  CWIDTH  words currently stored, 0..DEPTH.
- overflow  output  1  sticky: write attempted and rejected.
- underflow  output  1  sticky: read attempted while empty.

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0, standard-mode dout register=0. Memory contents are not reset.
- Flag values after reset: empty=1, full=0, almost_empty=1, almost_full=(almost_full_th==0).
- Pointers range 0..DEPTH-1 and wrap from DEPTH-1 to 0 by explicit compare, not by bit overflow.
- Acceptance rules:
  - ren = read & !empty.
  - wen = write & (!full | ren): a write is accepted when full only if a read is accepted in the same cycle.
  - Read on empty is always rejected, even with a simultaneous write; written data is readable from the next cycle.
- count next value:
  - count+1 if wen & !ren.
  - count-1 if ren & !wen.
  - unchanged otherwise.
- empty, full, almost_full and almost_empty are combinational from the registered count. They reflect an operation from the cycle after it is accepted.
- Threshold comparisons are unsigned at CWIDTH. Thresholds may change at any time; flags follow on the same cycle.
- Standard mode (FWFT=0):
  - On ren, dout <= mem[rd_ptr] at the clock edge, so data is valid the cycle after read.
  - dout holds its value when no read is accepted.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr] combinationally; it is valid whenever empty=0.
  - read pops the current word, and the next word appears after the edge.
  - dout is don't-care while empty.
- Memory write: on wen, mem[wr_ptr] <= din. A same-cycle read of a different address is unaffected. A same-address collision is only possible when full with ren, in which case the old word is read.
- flush:
  - Sets wr_ptr=rd_ptr=0 and count=0 at the next edge.
  - Overrides read and write in that cycle; those requests are neither performed nor counted as errors.
  - Standard-mode dout holds; overflow/underflow are unchanged.
- overflow: set on write & !wen & !flush. underflow: set on read & empty & !flush.
- clr_err clears both sticky flags. If a new error occurs in the same cycle, set wins.
- rst_n asserted mid-operation discards all content immediately; no partial state survives.

Test Plan:
- DEPTH=5, FWFT=0: reset -> empty=1, full=0, count=0, dout=0. Write 0xA0..0xA4 -> count=5, full=1. A sixth write -> count stays 5, overflow=1.
- DEPTH=5, FWFT=0: continuous write/read of 12 words (0x00..0x0B), interleaved with stalls -> dout sequence 0x00..0x0B in order, each word valid one cycle after its read; pointers wrap past index 4 twice.
- DEPTH=5, FWFT=1: write 0x11 -> next cycle empty=0, dout=0x11 with no read. Read -> 0x11 consumed, empty=1. Read while empty -> underflow=1. Then clr_err -> underflow=0.
- Full FIFO, read and write same cycle -> both accepted, count stays 5, no overflow. Empty FIFO, read and write same cycle -> read rejected, underflow=1, count=1.
- almost_full_th=3, almost_empty_th=1: fill 0..5 words -> almost_full high at count 3,4,5; almost_empty high at count 0,1. Change almost_full_th to 5 at count 4 -> almost_full drops the same cycle.
- Count=3, flush with read and write asserted -> next cycle count=0, empty=1, no error flags set. Separately, assert rst_n low mid-burst -> all outputs at reset values asynchronously.
